// File: rtl/ddr3_frame_reader_pkg.sv
// Shared types and defaults for the DDR3 frame reader: FSM states,
// default geometry and the request-size helper.
package ddr3_frame_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_REQ        = 3'd2,
    ST_WAIT_SPACE = 3'd3,
    ST_DRAIN      = 3'd4
  } state_t;

  localparam int DEF_ADDR_W     = 26;
  localparam int DEF_DATA_W     = 128;
  localparam int DEF_BURST_LEN  = 4;
  localparam int DEF_FIFO_DEPTH = 256;
  localparam int DEF_USED_W     = 9;
  localparam int DEF_MARGIN     = 4;

  // Beats for the next request: the burst size, or whatever is left if smaller.
  function automatic logic [2:0] min_size(input logic [23:0] remaining,
                                          input int unsigned burst_len);
    logic [2:0] len;
    if (remaining < 24'(burst_len)) len = remaining[2:0];
    else                            len = burst_len[2:0];
    return len;
  endfunction

endpackage

// File: rtl/ddr3_read_credit.sv
// Tracks beats requested but not yet returned and decides whether the pixel
// FIFO still has room for one more request of i_chk_len beats.
module ddr3_read_credit #(
  parameter int USED_W     = 9,
  parameter int FIFO_DEPTH = 256,
  parameter int MARGIN     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_accept,
  input  logic [2:0]        i_acc_len,
  input  logic              i_beat_vld,
  input  logic [2:0]        i_chk_len,
  input  logic [USED_W-1:0] i_fifo_used,
  output logic              o_can_issue,
  output logic              o_beat_ok,
  output logic              o_idle,
  output logic              o_last
);

  localparam int CW = USED_W + 2;
  localparam logic [CW-1:0] LIMIT = CW'(FIFO_DEPTH - MARGIN);

  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_acc_add;
  logic [CW-1:0] w_sum;

  assign w_acc_add = CW'(i_accept ? i_acc_len : 3'd0);

  // A request accepted this cycle already holds FIFO space for the next check;
  // a beat returning this cycle is not yet reflected in i_fifo_used, so it is
  // still counted.
  assign w_sum = CW'(i_fifo_used) + r_outstanding + w_acc_add + CW'(i_chk_len);

  assign o_can_issue = (w_sum <= LIMIT);
  assign o_beat_ok   = i_beat_vld && (r_outstanding != '0);
  assign o_idle      = (r_outstanding == '0);
  assign o_last      = (r_outstanding == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= r_outstanding + w_acc_add - CW'(o_beat_ok);
    end
  end

endmodule

// File: rtl/ddr3_frame_reader.sv
// Streams one frame per frame_start from DDR3 (Avalon-MM burst reads) into the
// VGA pixel FIFO, only issuing reads the FIFO is guaranteed to have room for.
module ddr3_frame_reader
  import ddr3_frame_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int USED_W     = DEF_USED_W,
  parameter int MARGIN     = DEF_MARGIN
) (
  input  logic              ddr3_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base_addr,
  input  logic [23:0]       frame_words,
  input  logic [USED_W-1:0] fifo_wr_used,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              ddr3_avl_ready,
  output logic              ddr3_avl_burstbegin,
  output logic [2:0]        ddr3_avl_size,
  output logic              ddr3_avl_read_req,
  output logic [ADDR_W-1:0] ddr3_avl_addr,
  input  logic              ddr3_avl_read_data_valid,
  input  logic [DATA_W-1:0] ddr3_avl_read_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_overrun,
  output logic              spurious_beat
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [23:0]       r_remaining;
  logic              r_abort;
  logic              r_read_req;
  logic              r_burstbegin;
  logic [2:0]        r_size;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_frame_done;
  logic              r_overrun;
  logic              r_spurious;

  logic              w_accept;
  logic [23:0]       w_rem_next;
  logic [23:0]       w_rem_sel;
  logic [2:0]        w_chk_len;
  logic              w_can_issue;
  logic              w_beat_ok;
  logic              w_idle;
  logic              w_last;

  assign w_accept   = r_read_req && ddr3_avl_ready;
  assign w_rem_next = r_remaining - 24'(r_size);

  // The credit check always looks at the request that would go out next.
  assign w_rem_sel  = (r_state == ST_ARM) ? frame_words :
                      (w_accept ? w_rem_next : r_remaining);
  assign w_chk_len  = min_size(w_rem_sel, BURST_LEN);

  ddr3_read_credit #(
    .USED_W    (USED_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MARGIN    (MARGIN)
  ) u_credit (
    .clk        (ddr3_clk),
    .rst_n      (reset_n),
    .i_accept   (w_accept),
    .i_acc_len  (r_size),
    .i_beat_vld (ddr3_avl_read_data_valid),
    .i_chk_len  (w_chk_len),
    .i_fifo_used(fifo_wr_used),
    .o_can_issue(w_can_issue),
    .o_beat_ok  (w_beat_ok),
    .o_idle     (w_idle),
    .o_last     (w_last)
  );

  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_abort      <= 1'b0;
      r_read_req   <= 1'b0;
      r_burstbegin <= 1'b0;
      r_size       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_spurious   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_wr_en      <= w_beat_ok;
      if (w_beat_ok) r_wr_data <= ddr3_avl_read_data;

      if (!enable) begin
        r_overrun  <= 1'b0;
        r_spurious <= 1'b0;
      end else begin
        if (frame_start && (r_state != ST_ARM)) r_overrun <= 1'b1;
        if (ddr3_avl_read_data_valid && !w_beat_ok) r_spurious <= 1'b1;
      end

      if (w_accept) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(r_size);
        r_remaining <= w_rem_next;
      end

      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_ARM;
        end

        ST_ARM: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (frame_start) begin
            r_cur_addr  <= frame_base_addr;
            r_remaining <= frame_words;
            r_abort     <= 1'b0;
            if (frame_words == '0) begin
              r_frame_done <= 1'b1;
            end else if (w_can_issue) begin
              r_state      <= ST_REQ;
              r_read_req   <= 1'b1;
              r_burstbegin <= 1'b1;
              r_size       <= w_chk_len;
            end else begin
              r_state <= ST_WAIT_SPACE;
            end
          end
        end

        // A request on the bus is always held until the slave takes it.
        ST_REQ: begin
          r_burstbegin <= 1'b0;
          if (w_accept) begin
            if (!enable) begin
              r_abort    <= 1'b1;
              r_read_req <= 1'b0;
              r_state    <= ST_DRAIN;
            end else if (w_rem_next == '0) begin
              r_read_req <= 1'b0;
              r_state    <= ST_DRAIN;
            end else if (w_can_issue) begin
              r_burstbegin <= 1'b1;
              r_size       <= w_chk_len;
            end else begin
              r_read_req <= 1'b0;
              r_state    <= ST_WAIT_SPACE;
            end
          end
        end

        ST_WAIT_SPACE: begin
          if (!enable) begin
            r_abort <= 1'b1;
            r_state <= ST_DRAIN;
          end else if (w_can_issue) begin
            r_state      <= ST_REQ;
            r_read_req   <= 1'b1;
            r_burstbegin <= 1'b1;
            r_size       <= w_chk_len;
          end
        end

        ST_DRAIN: begin
          if (!enable) r_abort <= 1'b1;
          if (w_beat_ok && w_last && !r_abort && enable) r_frame_done <= 1'b1;
          if (w_idle && !r_wr_en) begin
            r_state <= (r_abort || !enable) ? ST_IDLE : ST_ARM;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_wr_en          = r_wr_en;
  assign fifo_wr_data        = r_wr_data;
  assign ddr3_avl_read_req   = r_read_req;
  assign ddr3_avl_burstbegin = r_burstbegin;
  assign ddr3_avl_size       = r_size;
  assign ddr3_avl_addr       = r_cur_addr;
  assign busy                = (r_state != ST_IDLE) && (r_state != ST_ARM);
  assign frame_done          = r_frame_done;
  assign frame_overrun       = r_overrun;
  assign spurious_beat       = r_spurious;

endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Scoreboard bench: stimulus queues expected requests; a monitor checks every
// accepted request and FIFO write while a model slave returns beats.
module tb_ddr3_frame_reader;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 128;
  localparam int USED_W = 9;

  logic              ddr3_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              frame_start = 1'b0;
  logic [ADDR_W-1:0] frame_base_addr = '0;
  logic [23:0]       frame_words = '0;
  logic [USED_W-1:0] fifo_wr_used = '0;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              ddr3_avl_ready = 1'b1;
  logic              ddr3_avl_burstbegin;
  logic [2:0]        ddr3_avl_size;
  logic              ddr3_avl_read_req;
  logic [ADDR_W-1:0] ddr3_avl_addr;
  logic              ddr3_avl_read_data_valid = 1'b0;
  logic [DATA_W-1:0] ddr3_avl_read_data = '0;
  logic              busy, frame_done, frame_overrun, spurious_beat;

  ddr3_frame_reader dut (
    .ddr3_clk                (ddr3_clk),
    .reset_n                 (reset_n),
    .enable                  (enable),
    .frame_start             (frame_start),
    .frame_base_addr         (frame_base_addr),
    .frame_words             (frame_words),
    .fifo_wr_used            (fifo_wr_used),
    .fifo_wr_en              (fifo_wr_en),
    .fifo_wr_data            (fifo_wr_data),
    .ddr3_avl_ready          (ddr3_avl_ready),
    .ddr3_avl_burstbegin     (ddr3_avl_burstbegin),
    .ddr3_avl_size           (ddr3_avl_size),
    .ddr3_avl_read_req       (ddr3_avl_read_req),
    .ddr3_avl_addr           (ddr3_avl_addr),
    .ddr3_avl_read_data_valid(ddr3_avl_read_data_valid),
    .ddr3_avl_read_data      (ddr3_avl_read_data),
    .busy                    (busy),
    .frame_done              (frame_done),
    .frame_overrun           (frame_overrun),
    .spurious_beat           (spurious_beat)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int next_free = 0;
  int done_cnt = 0;
  int latency = 3;
  bit hold_beats = 1'b0;
  bit inj = 1'b0;
  bit zero_frame = 1'b0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [2:0]        exp_size_q[$];
  logic [DATA_W-1:0] exp_wr_q[$];
  logic [DATA_W-1:0] beat_q[$];
  int                beat_t[$];

  always @(posedge ddr3_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ddr3_clk);
    #1;
  endtask

  task automatic exp_req(input logic [ADDR_W-1:0] a, input logic [2:0] s);
    exp_addr_q.push_back(a);
    exp_size_q.push_back(s);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] a, input logic [23:0] w);
    frame_base_addr = a;
    frame_words     = w;
    frame_start     = 1'b1;
    tick(1);
    frame_start     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_wr_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_timeout"}, 128'(n < budget), 128'(1));
  endtask

  // Monitor: every accepted request and every FIFO write is checked here.
  always @(negedge ddr3_clk) begin
    logic [DATA_W-1:0] d;
    if (reset_n) begin
      if (fifo_wr_en) begin
        if (exp_wr_q.size() == 0) chk("unexpected_fifo_write", 128'(1), 128'(0));
        else chk("fifo_wr_data", fifo_wr_data, exp_wr_q.pop_front());
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_with_last_write",
            128'((fifo_wr_en || zero_frame) && exp_wr_q.size() == 0), 128'(1));
      end
      if (ddr3_avl_read_req && ddr3_avl_ready) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_request", 128'(1), 128'(0));
        end else begin
          chk("req_addr", 128'(ddr3_avl_addr), 128'(exp_addr_q.pop_front()));
          chk("req_size", 128'(ddr3_avl_size), 128'(exp_size_q.pop_front()));
        end
        if (next_free < cyc + latency) next_free = cyc + latency;
        for (int i = 0; i < int'(ddr3_avl_size); i++) begin
          d = {64'hC0FFEE00_00000000, 32'h0, 6'h0, ddr3_avl_addr + ADDR_W'(i)};
          beat_q.push_back(d);
          beat_t.push_back(next_free);
          exp_wr_q.push_back(d);
          next_free++;
        end
      end
    end
  end

  // Model slave: returns queued beats in order, or one injected stray beat.
  initial begin
    forever begin
      @(posedge ddr3_clk);
      #1;
      if (inj) begin
        ddr3_avl_read_data_valid = 1'b1;
        ddr3_avl_read_data       = 128'hBAD0_BAD0;
        inj                      = 1'b0;
      end else if (!hold_beats && beat_q.size() > 0 && beat_t[0] <= cyc) begin
        ddr3_avl_read_data_valid = 1'b1;
        ddr3_avl_read_data       = beat_q.pop_front();
        void'(beat_t.pop_front());
      end else begin
        ddr3_avl_read_data_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_fifo_wr_en", 128'(fifo_wr_en), 128'(0));
    chk("rst_read_req", 128'(ddr3_avl_read_req), 128'(0));
    chk("rst_burstbegin", 128'(ddr3_avl_burstbegin), 128'(0));
    chk("rst_size", 128'(ddr3_avl_size), 128'(0));
    chk("rst_addr", 128'(ddr3_avl_addr), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    chk("rst_overrun", 128'(frame_overrun), 128'(0));
    chk("rst_spurious", 128'(spurious_beat), 128'(0));
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(2);

    // Base frame: 16 words from 0x100 in four bursts of 4
    exp_req(26'h100, 3'd4);
    exp_req(26'h104, 3'd4);
    exp_req(26'h108, 3'd4);
    exp_req(26'h10C, 3'd4);
    pulse_start(26'h100, 24'd16);
    chk("base_first_req_next_cycle", 128'(ddr3_avl_read_req), 128'(1));
    chk("base_first_burstbegin", 128'(ddr3_avl_burstbegin), 128'(1));
    wait_idle("base", 200);
    chk("base_done_count", 128'(done_cnt), 128'(1));

    // Remainder: 10 words -> 4, 4, 2
    exp_req(26'h300, 3'd4);
    exp_req(26'h304, 3'd4);
    exp_req(26'h308, 3'd2);
    pulse_start(26'h300, 24'd10);
    wait_idle("remainder", 200);
    chk("remainder_done_count", 128'(done_cnt), 128'(2));

    // Backpressure: 247+0+4=251 fits, 247+4+4=255 does not, 240+4+4=248 fits
    hold_beats   = 1'b1;
    fifo_wr_used = 9'd247;
    exp_req(26'h400, 3'd4);
    exp_req(26'h404, 3'd4);
    pulse_start(26'h400, 24'd8);
    chk("bp_first_req", 128'(ddr3_avl_read_req), 128'(1));
    tick(1);
    chk("bp_blocked_after_accept", 128'(ddr3_avl_read_req), 128'(0));
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("bp_still_blocked", 128'(ddr3_avl_read_req), 128'(0));
    end
    fifo_wr_used = 9'd240;
    tick(1);
    chk("bp_req_after_space", 128'(ddr3_avl_read_req), 128'(1));
    fifo_wr_used = 9'd0;
    hold_beats   = 1'b0;
    wait_idle("backpressure", 200);
    chk("bp_done_count", 128'(done_cnt), 128'(3));

    // Ready stall with an overlapping frame_start
    ddr3_avl_ready = 1'b0;
    exp_req(26'h200, 3'd4);
    exp_req(26'h204, 3'd4);
    pulse_start(26'h200, 24'd8);
    chk("stall_burstbegin_first", 128'(ddr3_avl_burstbegin), 128'(1));
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        frame_base_addr = 26'h3FF_FF00;
        frame_words     = 24'd3;
        frame_start     = 1'b1;
      end
      tick(1);
      frame_start = 1'b0;
      chk("stall_read_req", 128'(ddr3_avl_read_req), 128'(1));
      chk("stall_addr", 128'(ddr3_avl_addr), 128'(26'h200));
      chk("stall_size", 128'(ddr3_avl_size), 128'(4));
      chk("stall_burstbegin_low", 128'(ddr3_avl_burstbegin), 128'(0));
    end
    chk("overrun_set", 128'(frame_overrun), 128'(1));
    ddr3_avl_ready = 1'b1;
    wait_idle("stall", 200);
    chk("stall_done_count", 128'(done_cnt), 128'(4));
    chk("overrun_sticky", 128'(frame_overrun), 128'(1));

    // Stray beat with nothing outstanding
    inj = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("stray_no_write", 128'(fifo_wr_en), 128'(0));
    end
    chk("spurious_set", 128'(spurious_beat), 128'(1));

    enable = 1'b0;
    tick(2);
    chk("overrun_cleared", 128'(frame_overrun), 128'(0));
    chk("spurious_cleared", 128'(spurious_beat), 128'(0));
    enable = 1'b1;
    tick(2);

    // Zero-length frame: frame_done only, no traffic
    zero_frame = 1'b1;
    pulse_start(26'h500, 24'd0);
    tick(2);
    chk("zero_done_count", 128'(done_cnt), 128'(5));
    chk("zero_not_busy", 128'(busy), 128'(0));
    zero_frame = 1'b0;

    // Enable drops while the second of four requests is on the bus
    exp_req(26'h600, 3'd4);
    exp_req(26'h604, 3'd4);
    pulse_start(26'h600, 24'd16);
    tick(1);
    enable = 1'b0;
    wait_idle("abort", 200);
    tick(4);
    chk("abort_no_done", 128'(done_cnt), 128'(5));
    chk("abort_idle", 128'(busy), 128'(0));
    chk("abort_no_req", 128'(ddr3_avl_read_req), 128'(0));

    // Re-enable from IDLE and run a single-burst frame
    enable = 1'b1;
    tick(2);
    exp_req(26'h700, 3'd4);
    pulse_start(26'h700, 24'd4);
    wait_idle("rearm", 200);
    chk("rearm_done_count", 128'(done_cnt), 128'(6));
    chk("req_queue_empty", 128'(exp_addr_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
